// File: rtl/sfx_pkg.sv
// sfx_pkg: shared types and constants for the sound-effect scheduler.
//   sfx_state_t  - scheduler states (IDLE, PLAY, GAP)
//   HP_W, DUR_W  - widths of the per-source half-period and duration fields
//   AMPL_DEFAULT - default square-wave amplitude
//   hp_floor()   - maps a zero half-period to 1 so the tone never stalls
package sfx_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      GAP  = 2'd2
   } sfx_state_t;

   localparam int HP_W  = 19;
   localparam int DUR_W = 10;

   localparam logic [31:0] AMPL_DEFAULT = 32'd10000000;

   function automatic logic [HP_W-1:0] hp_floor(input logic [HP_W-1:0] hp);
      return (hp == '0) ? HP_W'(1) : hp;
   endfunction

endpackage

// File: rtl/sfx_tone_gen.sv
// sfx_tone_gen: square-wave phase generator.
//   CLOCK_50     in   clock
//   reset        in   synchronous, active-high
//   load         in   restart the tone: latch half_period, clear counter, phase to +
//   half_period  in   half-period in clock cycles (0 is treated as 1)
//   phase        out  0 = positive half, 1 = negative half
// The counter runs 0..half_period, so each half lasts half_period+1 cycles.
module sfx_tone_gen
   import sfx_pkg::*;
(
   input  logic            CLOCK_50,
   input  logic            reset,
   input  logic            load,
   input  logic [HP_W-1:0] half_period,
   output logic            phase
);

   logic [HP_W-1:0] hp_q, hp_d;
   logic [HP_W-1:0] cnt_q, cnt_d;
   logic            phase_q, phase_d;

   always_comb begin
      hp_d    = hp_q;
      cnt_d   = cnt_q + 1'b1;
      phase_d = phase_q;
      if (load) begin
         hp_d    = hp_floor(half_period);
         cnt_d   = '0;
         phase_d = 1'b0;
      end else if (cnt_q >= hp_q) begin
         cnt_d   = '0;
         phase_d = ~phase_q;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         hp_q    <= HP_W'(1);
         cnt_q   <= '0;
         phase_q <= 1'b0;
      end else begin
         hp_q    <= hp_d;
         cnt_q   <= cnt_d;
         phase_q <= phase_d;
      end
   end

   assign phase = phase_q;

endmodule

// File: rtl/sfx_scheduler.sv
// sfx_scheduler: fixed-priority sound-effect scheduler feeding Audio_Controller.
//   CLOCK_50                 in   clock
//   reset                    in   synchronous, active-high
//   req                      in   one-cycle request pulses, index 0 highest priority
//   req_half_period          in   per-source half-period, slice i = [19i+18:19i]
//   req_dur_ms               in   per-source duration in ms, slice i = [10i+9:10i]
//   mute                     in   forces sample data to 0
//   audio_out_allowed        in   audio FIFO has space
//   write_audio_out          out  sample write strobe (registered copy of audio_out_allowed)
//   left/right_channel_...   out  sample data, +AMPL/-AMPL while playing, else 0
//   grant                    out  one-hot pulse when a request starts playing
//   active_id                out  index of the tone being played
//   busy                     out  high while in PLAY
//
// state | meaning
// IDLE  | no tone; start the lowest pending request
// PLAY  | tone running; duration counts ms ticks; lower pending index preempts
// GAP   | silent gap of GAP_MS ms before returning to IDLE
module sfx_scheduler
   import sfx_pkg::*;
#(
   parameter int          NUM_REQ = 4,
   parameter logic [31:0] AMPL    = AMPL_DEFAULT,
   parameter int          MS_DIV  = 50000,
   parameter int          GAP_MS  = 2
) (
   input  logic                     CLOCK_50,
   input  logic                     reset,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*HP_W-1:0]  req_half_period,
   input  logic [NUM_REQ*DUR_W-1:0] req_dur_ms,
   input  logic                     mute,
   input  logic                     audio_out_allowed,
   output logic                     write_audio_out,
   output logic [31:0]              left_channel_audio_out,
   output logic [31:0]              right_channel_audio_out,
   output logic [NUM_REQ-1:0]       grant,
   output logic [1:0]               active_id,
   output logic                     busy
);

   localparam int               MS_W     = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
   localparam logic [MS_W-1:0]  MS_LAST  = MS_W'(MS_DIV - 1);
   localparam logic [DUR_W-1:0] GAP_LEN  = DUR_W'(GAP_MS);
   localparam logic [DUR_W-1:0] TMR_ONE  = DUR_W'(1);
   localparam logic [31:0]      AMPL_NEG = 32'd0 - AMPL;

   sfx_state_t          state_q, state_d;
   logic [NUM_REQ-1:0]  pend_q, pend_d;
   logic [NUM_REQ-1:0]  pend_clr;
   logic [DUR_W-1:0]    tmr_q, tmr_d;
   logic [MS_W-1:0]     ms_q, ms_d;
   logic [NUM_REQ-1:0]  grant_q, grant_d;
   logic [1:0]          active_q, active_d;
   logic                busy_q, busy_d;
   logic                wr_q, wr_d;
   logic [31:0]         data_q, data_d;

   logic                pend_any;
   logic [1:0]          sel_id;
   logic [HP_W-1:0]     sel_hp;
   logic [DUR_W-1:0]    sel_dur;
   logic                tick;
   logic                start;
   logic                phase;

   // Fixed-priority pick: scanning downward leaves the lowest set index.
   always_comb begin
      pend_any = |pend_q;
      sel_id   = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (pend_q[i]) sel_id = 2'(i);
      end
      sel_hp  = req_half_period[sel_id*HP_W +: HP_W];
      sel_dur = req_dur_ms[sel_id*DUR_W +: DUR_W];
   end

   always_comb begin
      tick     = (ms_q == MS_LAST);
      ms_d     = tick ? '0 : ms_q + 1'b1;
      state_d  = state_q;
      tmr_d    = tmr_q;
      active_d = active_q;
      grant_d  = '0;
      pend_clr = '0;
      start    = 1'b0;

      unique case (state_q)
         IDLE: start = pend_any;
         PLAY: begin
            if (pend_any && (sel_id < active_q)) begin
               start = 1'b1;
            end else if (tick) begin
               if (tmr_q <= TMR_ONE) begin
                  state_d = GAP;
                  tmr_d   = GAP_LEN;
                  ms_d    = '0;
               end else begin
                  tmr_d = tmr_q - 1'b1;
               end
            end
         end
         GAP: begin
            if ((tmr_q == '0) || (tick && (tmr_q == TMR_ONE))) begin
               state_d = IDLE;
            end else if (tick) begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Tone load, shared by a fresh start from IDLE and by preemption.
      // A zero-length tone skips PLAY and goes straight to the gap.
      if (start) begin
         pend_clr[sel_id] = 1'b1;
         grant_d[sel_id]  = 1'b1;
         active_d         = sel_id;
         ms_d             = '0;
         if (sel_dur == '0) begin
            state_d = GAP;
            tmr_d   = GAP_LEN;
         end else begin
            state_d = PLAY;
            tmr_d   = sel_dur;
         end
      end

      // A new pulse in the same cycle as the grant keeps the bit set.
      pend_d = (pend_q & ~pend_clr) | req;
      busy_d = (state_d == PLAY);
      wr_d   = audio_out_allowed;
      data_d = ((state_q == PLAY) && !mute) ? (phase ? AMPL_NEG : AMPL) : '0;
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q  <= IDLE;
         pend_q   <= '0;
         tmr_q    <= '0;
         ms_q     <= '0;
         grant_q  <= '0;
         active_q <= '0;
         busy_q   <= 1'b0;
         wr_q     <= 1'b0;
         data_q   <= '0;
      end else begin
         state_q  <= state_d;
         pend_q   <= pend_d;
         tmr_q    <= tmr_d;
         ms_q     <= ms_d;
         grant_q  <= grant_d;
         active_q <= active_d;
         busy_q   <= busy_d;
         wr_q     <= wr_d;
         data_q   <= data_d;
      end
   end

   sfx_tone_gen u_tone_gen (
      .CLOCK_50    (CLOCK_50),
      .reset       (reset),
      .load        (start),
      .half_period (sel_hp),
      .phase       (phase)
   );

   assign write_audio_out         = wr_q;
   assign left_channel_audio_out  = data_q;
   assign right_channel_audio_out = data_q;
   assign grant                   = grant_q;
   assign active_id               = active_q;
   assign busy                    = busy_q;

endmodule

// File: doc/sfx_scheduler.md
# sfx_scheduler

Sound-effect scheduler between game logic and `Audio_Controller`. It accepts tone requests from up to four game sources (hit, miss, level-up, game-over) and arbitrates them by fixed priority. It plays one square-wave tone at a time for a programmed duration and keeps the audio-out FIFO fed through the `audio_out_allowed` / `write_audio_out` handshake. Silence (zero samples) is written whenever no tone is active.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters; index 0 is highest priority.
- `AMPL`, 32'd10000000, square-wave amplitude; samples are +AMPL / -AMPL.
- `MS_DIV`, 50000, CLOCK_50 cycles per millisecond tick.
- `GAP_MS`, 2, silent gap in ms after each tone.

Ports:
- `CLOCK_50`  in  1  sole clock, all logic on posedge.
- `reset`  in  1  synchronous, active-high.
- `req`  in  NUM_REQ  one-cycle request pulses, one bit per source.
- `req_half_period`  in  NUM_REQ*19  per-source half-period in CLOCK_50 cycles; slice i = [19i+18:19i].
- `req_dur_ms`  in  NUM_REQ*10  per-source tone duration in ms.
- `mute`  in  1  forces sample value 0; scheduling is unaffected.
- `audio_out_allowed`  in  1  FIFO has space (from `Audio_Controller`).
- `write_audio_out`  out  1  sample write strobe.
- `left_channel_audio_out`, `right_channel_audio_out`  out  32  sample data; both channels identical.
- `grant`  out  NUM_REQ  one-hot, one-cycle pulse when a request starts playing.
- `active_id`  out  2  index of the tone playing; valid while `busy`.
- `busy`  out  1  high in PLAY.

## Operation
- Pending latch: `req[i]`=1 sets `pending[i]`. The bit clears when granted. If set and clear fall in the same cycle, set wins, so the request is replayed later. Repeated requests while pending collapse into one.
- States:
  - IDLE: if any pending bit is set, pick the lowest set index. Load its half-period (0 is treated as 1) and duration. Pulse `grant[i]`, clear `pending[i]`, go to PLAY. With no pending bits, remain in IDLE.
  - PLAY: the half-period counter counts to the loaded value, then toggles phase and restarts. Phase starts at + on entry. On each ms tick, duration decrements. When duration reaches 0 (or a tone is loaded with duration 0), go to GAP.
  - GAP: silent for GAP_MS ticks, then go to IDLE.
- Preemption: in PLAY, if a pending index is lower than `active_id`, reload the tone for that index immediately. This pulses grant, resets phase to +, and restarts duration with no gap. The preempted tone is dropped and is not re-queued.
- Samples: `write_audio_out` = `audio_out_allowed` in every state. Data is ±AMPL in PLAY and 0 in IDLE and GAP, or 0 whenever `mute` is high.
- ms prescaler: a free-running 0..MS_DIV-1 counter that restarts at 0 on every tone load and every GAP entry.

## Timing
- Reset values: `write_audio_out`=0, sample data=0, `grant`=0, `busy`=0, `active_id`=0, all pending bits=0, state=IDLE.
- Outputs are registered. `write_audio_out` and data lag `audio_out_allowed` by 1 cycle.
- A `req` pulse in cycle n with the scheduler in IDLE gives `grant` in cycle n+2 and `busy` from n+2.
- The first phase toggle occurs (half_period+1) cycles after grant.
- Tone length is dur_ms×MS_DIV cycles ±1.
- Reset asserted mid-PLAY: outputs return to reset values at the next edge, and pending requests are lost.
- `audio_out_allowed` low never stalls the timers; samples are simply not written.

## Structure
- Package `sfx_pkg`:
  - state enum {IDLE, PLAY, GAP}
  - widths `HP_W`=19, `DUR_W`=10
  - default `AMPL`
- Sub-module `sfx_tone_gen`: half-period counter plus phase flop, with `load`/`half_period` inputs and a `phase` output.
- Arbiter, pending latch and timers live in the top.

## Test plan
- Single request: `req[2]` with hp=3000, dur=1; use MS_DIV=100 for the bench. Expect `grant[2]` at n+2, phase toggling every 3001 cycles, busy for 100 cycles, GAP silence for 200 cycles, then IDLE.
- Simultaneous `req[1]` and `req[3]` pulses. Expect `grant[1]` first; after that tone plus gap, `grant[3]`. Samples are 0 during the gap.
- Preemption: `req[3]` playing, then `req[0]`. Expect `grant[0]` 2 cycles later, phase restarting at +AMPL, and `req[3]` never resuming.
- Edge values: dur=0 gives a grant, no ±AMPL samples, then the gap. hp=0 makes phase toggle every 2 cycles. `mute`=1 keeps data 0 while `busy`=1.
- Flow control and reset: hold `audio_out_allowed` low for 500 cycles with no writes and confirm duration is still consumed. Assert `reset` mid-PLAY and check all outputs are 0 at the next edge.
